adder_share_arbiter: RTL and testbench

- Shares one registered integer adder between N_REQ requesters using round-robin arbitration.
- Each requester presents an operand pair with a valid/ready handshake. Results return on a shared data bus, steered by a one-hot response-valid.
- Sits between multiple client modules and the single add resource, which those clients reach through a modport-style task import. This block is the sequencer that serialises their calls.

---
 rtl/adder_share_arbiter.sv | 101 ++++++++++
 tb/tb_adder_share_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one registered adder among N_REQ requesters.
// Accept -> response valid two cycles later; response held until its owner takes it, requests stall meanwhile.
module adder_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [N_REQ-1:0]       i_req_valid,
   output logic [N_REQ-1:0]       o_req_ready,
   input  logic [N_REQ*WIDTH-1:0] i_req_a,
   input  logic [N_REQ*WIDTH-1:0] i_req_b,
   output logic [N_REQ-1:0]       o_rsp_valid,
   input  logic [N_REQ-1:0]       i_rsp_ready,
   output logic [WIDTH-1:0]       o_rsp_data,
   output logic                   o_rsp_carry,
   output logic [ID_W-1:0]        o_rsp_id,
   output logic                   o_busy,
   output logic [15:0]            o_op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  win_id;
   logic             win_vld;
   logic [ID_W:0]    cand;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_carry;
   logic [ID_W-1:0]  rsp_id;
   logic [15:0]      op_count;
   logic             rsp_acc;

   // Scan from the highest offset down so the requester nearest the pointer wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      cand    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (i_req_valid[cand[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_id  = cand[ID_W-1:0];
         end
      end
   end

   assign rsp_acc = (state == RESP) && i_rsp_ready[rsp_id];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_id    <= '0;
         op_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  op_a   <= i_req_a[int'(win_id)*WIDTH +: WIDTH];
                  op_b   <= i_req_b[int'(win_id)*WIDTH +: WIDTH];
                  rsp_id <= win_id;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               {rsp_carry, rsp_data} <= {1'b0, op_a} + {1'b0, op_b};
               state                 <= RESP;
            end
            RESP: begin
               if (rsp_acc) begin
                  op_count <= op_count + 16'd1;
                  ptr      <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_req_ready = (state == IDLE && win_vld) ? (N_REQ'(1) << win_id) : '0;
   assign o_rsp_valid = (state == RESP) ? (N_REQ'(1) << rsp_id) : '0;
   assign o_rsp_data  = rsp_data;
   assign o_rsp_carry = rsp_carry;
   assign o_rsp_id    = rsp_id;
   assign o_busy      = (state != IDLE);
   assign o_op_count  = op_count;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed vector table, hand sequences and a
// randomized phase, all checked against a transaction-level reference model.
module tb_adder_share_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready = '0;
   logic [W-1:0]   rsp_data;
   logic           rsp_carry;
   logic [1:0]     rsp_id;
   logic           busy;
   logic [15:0]    op_count;

   adder_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(rsp_data), .o_rsp_carry(rsp_carry), .o_rsp_id(rsp_id),
      .o_busy(busy), .o_op_count(op_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: phase 0 = free, 1 = operands taken, 2 = result offered
   int          m_phase = 0;
   int          m_ptr = 0;
   int          m_id = 0;
   logic [32:0] m_sum = '0;
   logic [15:0] m_count = '0;
   logic [N-1:0] last_hs = '0;
   int          grant_log[$];
   int          grant_cyc[$];
   logic [W-1:0] rsp_dat_log[$];

   always @(negedge clk) begin
      int w;
      if (!rst_n) begin
         m_phase = 0;
         m_ptr   = 0;
         m_count = '0;
         last_hs = '0;
      end else begin
         last_hs = req_ready & req_valid;
         chk("m_op_count", op_count, m_count);
         case (m_phase)
            0: begin
               w = -1;
               for (int i = 0; i < N; i++)
                  if (w < 0 && req_valid[(m_ptr + i) % N]) w = (m_ptr + i) % N;
               chk("m_idle_busy", busy, 0);
               chk("m_idle_rsp_valid", rsp_valid, 0);
               chk("m_req_ready", req_ready, (w < 0) ? 0 : (1 << w));
               if (w >= 0) begin
                  m_id    = w;
                  m_sum   = {1'b0, req_a[w*W +: W]} + {1'b0, req_b[w*W +: W]};
                  m_phase = 1;
                  grant_log.push_back(w);
                  grant_cyc.push_back(cyc);
               end
            end
            1: begin
               chk("m_exec_busy", busy, 1);
               chk("m_exec_ready", req_ready, 0);
               chk("m_exec_rsp_valid", rsp_valid, 0);
               m_phase = 2;
            end
            default: begin
               chk("m_resp_busy", busy, 1);
               chk("m_resp_ready", req_ready, 0);
               chk("m_rsp_valid", rsp_valid, 1 << m_id);
               chk("m_rsp_data", rsp_data, m_sum[W-1:0]);
               chk("m_rsp_carry", rsp_carry, m_sum[W]);
               chk("m_rsp_id", rsp_id, m_id);
               if (rsp_ready[m_id]) begin
                  m_count = m_count + 16'd1;
                  m_ptr   = (m_id + 1) % N;
                  m_phase = 0;
                  rsp_dat_log.push_back(rsp_data);
               end
            end
         endcase
      end
   end

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_sum;
      logic        exp_carry;
      int          hold;
   } vec_t;

   vec_t        vecs[6];
   logic [15:0] exp_count = '0;

   // One isolated transaction; while held, the wrong ready bits are raised and
   // the next requester asserts valid then withdraws it before the block frees.
   task automatic run_single(input vec_t v);
      logic [N-1:0] oh;
      oh = 4'b0001 << v.id;
      req_a[v.id*W +: W] = v.a;
      req_b[v.id*W +: W] = v.b;
      req_valid = oh;
      #1;
      chk("grant_ready", req_ready, oh);
      step();
      req_valid = '0;
      chk("exec_no_rsp", rsp_valid, 0);
      step();
      for (int h = 0; h <= v.hold; h++) begin
         chk("rsp_valid", rsp_valid, oh);
         chk("rsp_data", rsp_data, v.exp_sum);
         chk("rsp_carry", rsp_carry, v.exp_carry);
         chk("rsp_id", rsp_id, v.id);
         chk("held_no_ready", req_ready, 0);
         if (h < v.hold) begin
            rsp_ready = ~oh;
            req_valid = 4'b0001 << ((v.id + 1) % N);
            step();
         end
      end
      req_valid = '0;
      rsp_ready = oh;
      step();
      rsp_ready = '0;
      exp_count = exp_count + 16'd1;
      chk("busy_after", busy, 0);
      chk("valid_after", rsp_valid, 0);
      chk("op_count", op_count, exp_count);
      step();
      chk("no_stray_rsp", rsp_valid, 0);
   endtask

   int   exp_order[5];
   vec_t tmp;

   initial begin
      vecs[0] = '{2, 32'd5,          32'd7,          32'd12,         1'b0, 0};
      vecs[1] = '{0, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b1, 5};
      vecs[2] = '{3, 32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1, 2};
      vecs[3] = '{1, 32'd1234,       32'd1111,       32'd2345,       1'b0, 1};
      vecs[4] = '{2, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1'b0, 0};
      vecs[5] = '{3, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 0};
      exp_order = '{0, 1, 2, 3, 0};

      // Reset state
      step();
      step();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_carry", rsp_carry, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_single(vecs[i]);

      // Round robin with every requester asserting continuously
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      grant_log.delete();
      grant_cyc.delete();
      rsp_dat_log.delete();
      for (int k = 0; k < N; k++) begin
         req_a[k*W +: W] = k;
         req_b[k*W +: W] = 32'd10;
      end
      req_valid = 4'hF;
      rsp_ready = 4'hF;
      for (int n = 0; n < 40 && rsp_dat_log.size() < 5; n++) step();
      req_valid = '0;
      repeat (4) step();
      rsp_ready = '0;
      chk("rr_completed", rsp_dat_log.size() >= 5, 1);
      for (int i = 0; i < 5; i++) begin
         chk("rr_grant_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
         chk("rr_result", (i < rsp_dat_log.size()) ? rsp_dat_log[i] : 32'hDEAD_BEEF, 10 + exp_order[i]);
      end
      for (int i = 1; i < 5; i++)
         chk("rr_spacing", (i < grant_cyc.size()) ? grant_cyc[i] - grant_cyc[i-1] : -1, 3);

      // Reset while a result is pending; pointer must restart at 0
      tmp = '{2, 32'd20, 32'd22, 32'd42, 1'b0, 0};
      exp_count = op_count;
      run_single(tmp);
      req_a[3*W +: W] = 32'd1;
      req_b[3*W +: W] = 32'd1;
      req_valid = 4'b1000;
      #1;
      chk("ptr_follows_last", req_ready, 4'b1000);
      step();
      step();
      chk("pre_reset_rsp", rsp_valid, 4'b1000);
      rst_n = 1'b0;
      req_a[1*W +: W] = 32'd3;
      req_b[1*W +: W] = 32'd4;
      req_valid = 4'b1010;
      step();
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_op_count", op_count, 0);
      rst_n = 1'b1;
      #1;
      chk("midrst_ptr_zero", req_ready, 4'b0010);
      rsp_ready = 4'hF;
      repeat (6) step();
      req_valid = '0;
      repeat (4) step();
      rsp_ready = '0;

      // Counter wrap via preload
      force dut.op_count = 16'hFFFF;
      m_count = 16'hFFFF;
      exp_count = 16'hFFFF;
      step();
      release dut.op_count;
      #1;
      chk("preload", op_count, 16'hFFFF);
      tmp = '{1, 32'd3, 32'd4, 32'd7, 1'b0, 0};
      run_single(tmp);
      chk("wrap_zero", op_count, 16'h0000);

      // Randomized traffic; valids held until handshake, occasionally withdrawn
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            if (last_hs[k] || !req_valid[k]) begin
               req_valid[k] = ($urandom_range(0, 2) == 0);
               req_a[k*W +: W] = $urandom;
               req_b[k*W +: W] = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[k] = 1'b0;
            end
         end
         rsp_ready = 4'($urandom);
         step();
      end
      req_valid = '0;
      rsp_ready = 4'hF;
      repeat (6) step();
      chk("drain_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached without completion");
      $fatal(1, "timeout");
   end

endmodule
